// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_divider_pkg;

    // Default divisor/remainder width; dividend and quotient are twice this.
    localparam int unsigned DivN = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int unsigned N = DivN
) (
    input  logic [N-1:0] part_rem,
    input  logic         next_bit,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] new_rem,
    output logic         q_bit
);

    logic [N:0] shifted;

    // Compare and conditionally subtract. part_rem < divisor, so the difference
    // always fits in N bits and can be taken modulo 2^N.
    always_comb begin
        shifted = {part_rem, next_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        new_rem = q_bit ? (shifted[N-1:0] - divisor) : shifted[N-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: 2N-bit dividend by N-bit divisor, one bit per cycle.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned N = DivN
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           dbz
);

    localparam int unsigned CntW = $clog2(2 * N) + 1;
    localparam logic [CntW-1:0] LastStep = CntW'(2 * N - 1);

    div_state_e state_q, state_d;

    // quo_q starts as the dividend and is shifted left each step; quotient bits
    // enter at the LSB, so after 2N steps it holds the full quotient.
    logic [2*N-1:0] quo_q;
    logic [N-1:0]   rem_q;
    logic [N-1:0]   div_q;
    logic [CntW-1:0] cnt_q;
    logic           dbz_q;

    logic [N-1:0]   step_rem;
    logic           step_q;

    div_step #(
        .N (N)
    ) u_step (
        .part_rem (rem_q),
        .next_bit (quo_q[2*N-1]),
        .divisor  (div_q),
        .new_rem  (step_rem),
        .q_bit    (step_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start only matters in idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (divisor == '0) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (cnt_q == LastStep) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    // Datapath: capture operands on accept, one restoring step per calc cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quo_q <= {(2 * N){1'b1}};
                            rem_q <= '0;
                            dbz_q <= 1'b1;
                        end else begin
                            quo_q <= dividend;
                            rem_q <= '0;
                            div_q <= divisor;
                            cnt_q <= '0;
                            dbz_q <= 1'b0;
                        end
                    end
                end
                StCalc: begin
                    quo_q <= {quo_q[2*N-2:0], step_q};
                    rem_q <= step_rem;
                    cnt_q <= cnt_q + CntW'(1);
                end
                default: ;
            endcase
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider with N=4.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;

    always #5 clk = ~clk;

    seq_divider #(
        .N (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Results of the most recent run_op.
    int         lat;
    int         ndone;
    logic [7:0] rq;
    logic [3:0] rr;
    logic       rdbz;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation; lat counts cycles from the accept edge (the cycle
    // starting at that edge is 1). Returns one cycle after done, in idle.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        ndone = 0;
        for (int n = 1; n <= 20; n++) begin
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat  = n;
                    rq   = quotient;
                    rr   = remainder;
                    rdbz = dbz;
                end
            end
            if (lat >= 0 && n == lat + 1) break;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int prod;
        int ok;

        vecs[0]  = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 9};
        vecs[1]  = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 9};
        vecs[2]  = '{8'd0,   4'd5,  8'd0,   4'd0, 1'b0, 9};
        vecs[3]  = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 9};
        vecs[4]  = '{8'd100, 4'd0,  8'd255, 4'd0, 1'b1, 1};
        vecs[5]  = '{8'd9,   4'd3,  8'd3,   4'd0, 1'b0, 9};
        vecs[6]  = '{8'd17,  4'd4,  8'd4,   4'd1, 1'b0, 9};
        vecs[7]  = '{8'd1,   4'd15, 8'd0,   4'd1, 1'b0, 9};
        vecs[8]  = '{8'd15,  4'd15, 8'd1,   4'd0, 1'b0, 9};
        vecs[9]  = '{8'd254, 4'd2,  8'd127, 4'd0, 1'b0, 9};
        vecs[10] = '{8'd128, 4'd9,  8'd14,  4'd2, 1'b0, 9};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset quotient", 32'(quotient), 0);
        check("reset remainder", 32'(remainder), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset dbz", 32'(dbz), 0);

        // rst wins over start in the same cycle
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 4'd5;
        @(posedge clk);
        #1;
        check("rst priority busy", 32'(busy), 0);
        start = 1'b0;
        rst   = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d quotient", i), 32'(rq), 32'(vecs[i].q));
            check($sformatf("vec%0d remainder", i), 32'(rr), 32'(vecs[i].r));
            check($sformatf("vec%0d dbz", i), 32'(rdbz), 32'(vecs[i].z));
            check($sformatf("vec%0d done count", i), 32'(ndone), 1);
            check($sformatf("vec%0d hold quotient", i), 32'(quotient), 32'(vecs[i].q));
            check($sformatf("vec%0d idle busy", i), 32'(busy), 0);
        end

        // start re-pulsed with new operands during calc and the done cycle
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        ndone = 0;
        for (int n = 1; n <= 14; n++) begin
            if (n == 3) begin
                start    = 1'b1;
                dividend = 8'd50;
                divisor  = 4'd5;
            end
            if (n == 10) start = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = n;
                    rq  = quotient;
                    rr  = remainder;
                end
            end
            if (n == 11) check("repulse idle after done", 32'(busy), 0);
            @(posedge clk);
            #1;
        end
        check("repulse latency", 32'(lat), 9);
        check("repulse done count", 32'(ndone), 1);
        check("repulse quotient", 32'(rq), 28);
        check("repulse remainder", 32'(rr), 4);

        // rst mid-calc aborts without a done pulse
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int n = 1; n <= 4; n++) begin
            if (done) ndone++;
            if (n < 4) begin
                @(posedge clk);
                #1;
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort quotient", 32'(quotient), 0);
        check("abort remainder", 32'(remainder), 0);
        check("abort busy", 32'(busy), 0);
        check("abort dbz", 32'(dbz), 0);
        for (int n = 0; n < 12; n++) begin
            if (done) ndone++;
            @(posedge clk);
            #1;
        end
        check("abort done count", 32'(ndone), 0);
        run_op(8'd17, 4'd4);
        check("post-abort quotient", 32'(rq), 4);
        check("post-abort remainder", 32'(rr), 1);
        check("post-abort latency", 32'(lat), 9);

        // Exhaustive identity sweep over all nonzero divisors
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(8'(a), 4'(b));
                prod = int'(rq) * b + int'(rr);
                ok   = (lat == 9 && prod == a && int'(rr) < b && rdbz == 1'b0) ? 1 : 0;
                n_cmp++;
                if (ok == 0) begin
                    n_bad++;
                    $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%0d lat=%0d, required q*d+r=%0d r<%0d dbz=0 lat=9",
                             a, b, rq, rr, rdbz, lat, a, b);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL take parameter: N, default 4, divisor and remainder width; dividend and quotient are 2N bits.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: dividend  input  2N  unsigned numerator; captured when start is accepted.
REQ-006 SHALL have port: divisor  input  N  unsigned denominator; captured when start is accepted.
REQ-007 SHALL have port: quotient  output  2N  unsigned result.
REQ-008 SHALL have port: remainder  output  N  unsigned result.
REQ-009 SHALL have port: busy  output  1  high in CALC and DONE.
REQ-010 SHALL have port: done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port: dbz  output  1  divide-by-zero flag for the last operation.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE.
REQ-013 SHALL go from IDLE to CALC when start=1 and divisor!=0, and capture the operands at that edge.
REQ-014 SHALL perform one restoring step per cycle in CALC:
- shift the (N+1)-bit partial remainder left, bringing in the next dividend MSB;
- if partial >= divisor, subtract the divisor and set the quotient bit to 1; else set it to 0.
REQ-015 SHALL perform exactly 2N steps in CALC, then enter DONE.
REQ-016 SHALL assert done for exactly one cycle in DONE, 2N+1 cycles after the start-accept edge.
REQ-017 SHALL return from DONE to IDLE unconditionally.
REQ-018 SHALL, when start=1 and divisor=0 in IDLE, go directly to DONE, with quotient={2N{1}}, remainder=0 and dbz=1.
REQ-019 SHALL clear dbz on every accepted start with divisor!=0.
REQ-020 SHALL ignore start while busy=1, including in the DONE cycle.
REQ-021 SHALL hold quotient, remainder and dbz stable from done until the next accepted start; they MAY change during CALC.
REQ-022 SHALL ignore dividend and divisor changes after capture.
REQ-023 SHALL meet dividend = quotient*divisor + remainder and remainder < divisor for every divisor!=0.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, set the state to IDLE and quotient, remainder, busy, done and dbz to 0.
REQ-025 SHALL, on rst asserted mid-CALC, abort the operation with no done pulse.
REQ-026 SHALL give rst priority over start in the same cycle.

Structure
REQ-027 SHALL place the state encoding (IDLE/CALC/DONE) and the default width constant N=4 in the shared div package.
REQ-028 SHALL implement the single restoring step (compare, subtract, quotient bit) as combinational sub-module div_step; the FSM and counter stay in seq_divider.
REQ-029 SHALL use a step counter of clog2(2N)+1 bits.

Verification
REQ-030 SHALL cover: 200/7 -> quotient=28, remainder=4, dbz=0, done exactly 9 cycles after start-accept edge.
REQ-031 SHALL cover: 255/15 -> quotient=17, remainder=0; 0/5 -> quotient=0, remainder=0; 255/1 -> quotient=255, remainder=0.
REQ-032 SHALL cover: 100/0 -> done on the next cycle, quotient=255, remainder=0, dbz=1; then 9/3 -> quotient=3, dbz=0.
REQ-033 SHALL cover: start re-pulsed with 50/5 during CALC of 200/7 -> result stays 28 r4, exactly one done.
REQ-034 SHALL cover: rst pulsed at step 4 of 200/7 -> no done, all outputs 0; a fresh 17/4 -> quotient=4, remainder=1.
REQ-035 SHALL cover: exhaustive sweep of all 256x15 nonzero pairs against the REQ-023 identity.
